// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic inter-stage pipeline latches.
// Control field layout, MEM->WB payload packing and legal chain depths.
package pipe_pkg;

    localparam int CTRL_REG_WRITE_BIT = 0;
    localparam int CTRL_DST_LSB       = 1;
    localparam int CTRL_DST_W         = 4;

    localparam int WB_FIELD_W   = 16;
    localparam int WB_WDATA_LSB = 0;
    localparam int WB_RDATA_LSB = 16;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 4;

    typedef struct packed {
        logic [WB_FIELD_W-1:0] read_data;
        logic [WB_FIELD_W-1:0] write_data;
    } mem_wb_data_t;

    function automatic bit depth_ok(int d);
        return (d >= DEPTH_MIN) && (d <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/pipe_latch_slot.sv
// One elastic pipeline slot: valid, control and payload registers.
// Invalid loads zero the control field and leave the payload untouched.
module pipe_latch_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              flush,
    input  logic              prev_valid,
    input  logic [CTRL_W-1:0] prev_ctrl,
    input  logic [DATA_W-1:0] prev_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load_en) begin
            valid <= prev_valid;
            if (prev_valid) begin
                ctrl <= prev_ctrl;
                data <= prev_data;
            end else begin
                ctrl <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_latch_chain.sv
// Chain of DEPTH elastic slots with bubble collapsing, flush and occupancy.
// Slot 0 faces the producer, slot DEPTH-1 drives the consumer.
module pipe_latch_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  occupancy
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipe_latch_chain: DEPTH out of range");
    end

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  ld_v;
    logic [DEPTH-1:0]  v_nxt;
    logic [CTRL_W-1:0] c    [DEPTH];
    logic [CTRL_W-1:0] ld_c [DEPTH];
    logic [DATA_W-1:0] d    [DEPTH];
    logic [DATA_W-1:0] ld_d [DEPTH];
    logic [CNT_W-1:0]  occ_q;
    logic [CNT_W-1:0]  occ_nxt;

    // A slot may move when it is empty or everything ahead of it moves.
    always_comb begin : adv_ripple
        logic rip;
        adv = '0;
        rip = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rip    = ~v[i] | rip;
            adv[i] = rip;
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        ld_v    = '0;
        ld_v[0] = in_valid & adv[0];
        ld_c[0] = in_ctrl;
        ld_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            ld_v[i] = v[i-1];
            ld_c[i] = c[i-1];
            ld_d[i] = d[i-1];
        end
    end

    always_comb begin
        v_nxt   = '0;
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_nxt[i] = ~flush & (adv[i] ? ld_v[i] : v[i]);
            occ_nxt  = occ_nxt + CNT_W'(v_nxt[i]);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_latch_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_en    (adv[g]),
            .flush      (flush),
            .prev_valid (ld_v[g]),
            .prev_ctrl  (ld_c[g]),
            .prev_data  (ld_d[g]),
            .valid      (v[g]),
            .ctrl       (c[g]),
            .data       (d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_nxt;
        end
    end

    assign occupancy = occ_q;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    // Bubbles must never present REG_WRITE downstream.
    assign out_ctrl  = out_valid ? c[DEPTH-1] : '0;

endmodule

// File: tb/tb_pipe_latch_chain.sv
// Bench for pipe_latch_chain: directed table, token-position model with
// random traffic, mid-cycle reset and a DEPTH=1 scoreboard run.
module tb_pipe_latch_chain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv2 = 1'b0, ir2, fl2 = 1'b0, ov2, or2 = 1'b0;
    logic [31:0] id2 = '0, od2;
    logic [4:0]  ic2 = '0, oc2;
    logic [1:0]  occ2;

    logic        iv1 = 1'b0, ir1, fl1 = 1'b0, ov1, or1 = 1'b0;
    logic [31:0] id1 = '0, od1;
    logic [4:0]  ic1 = '0, oc1;
    logic [0:0]  occ1;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_latch_chain #(.DATA_W(32), .CTRL_W(5), .DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_ctrl(ic2),
        .flush(fl2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ctrl(oc2),
        .occupancy(occ2)
    );

    pipe_latch_chain #(.DATA_W(32), .CTRL_W(5), .DEPTH(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_ctrl(ic1),
        .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] dat;
        logic [4:0]  ctl;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_dat;
        logic [4:0]  e_ctl;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [31:0] dat, logic [4:0] ctl,
                                logic ordy, logic fl, logic e_ov,
                                logic [31:0] e_dat, logic [4:0] e_ctl,
                                logic [1:0] e_occ, logic e_ir);
        vec_t r;
        r.iv = iv; r.dat = dat; r.ctl = ctl; r.ordy = ordy; r.fl = fl;
        r.e_ov = e_ov; r.e_dat = e_dat; r.e_ctl = e_ctl;
        r.e_occ = e_occ; r.e_ir = e_ir;
        return r;
    endfunction

    // Model: queue of entries (oldest first), each at a slot position.
    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
        int          pos;
    } ent_t;

    localparam int MD = 2;
    ent_t q[$];

    task automatic model_cycle(int cyc);
        ent_t nq[$];
        ent_t e;
        bit   popped, e_ov, e_ir;
        int   ahead, lowest;
        @(negedge clk);
        e_ov   = (q.size() > 0) && (q[0].pos == MD - 1);
        popped = e_ov && or2;
        chk($sformatf("rnd%0d out_valid", cyc), 32'(ov2), 32'(e_ov));
        chk($sformatf("rnd%0d occupancy", cyc), 32'(occ2), 32'(q.size()));
        chk($sformatf("rnd%0d out_ctrl", cyc), 32'(oc2),
            e_ov ? 32'(q[0].c) : 32'd0);
        if (e_ov)
            chk($sformatf("rnd%0d out_data", cyc), od2, q[0].d);
        ahead  = MD;
        lowest = MD;
        foreach (q[i]) begin
            if (i == 0 && popped) continue;
            e = q[i];
            if (e.pos + 1 < ahead) e.pos++;
            ahead  = e.pos;
            lowest = e.pos;
            nq.push_back(e);
        end
        e_ir = (lowest != 0);
        chk($sformatf("rnd%0d in_ready", cyc), 32'(ir2), 32'(e_ir));
        q = nq;
        if (fl2) q.delete();
        else if (iv2 && e_ir) q.push_back('{id2, ic2, 0});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A = 32'h0000_1111;
    localparam logic [31:0] B = 32'h0000_2222;
    localparam logic [31:0] C = 32'h0000_3333;
    localparam logic [4:0]  CA = 5'b00011;
    localparam logic [4:0]  CB = 5'b10101;
    localparam logic [4:0]  CC = 5'b01110;

    initial begin
        int sent, got, or_hi;
        logic [31:0] sb[$];
        logic [31:0] nxt;
        logic e_ir1;

        // Reset state while rst_n is low.
        #2;
        chk("rst out_valid", 32'(ov2), 32'd0);
        chk("rst out_ctrl", 32'(oc2), 32'd0);
        chk("rst out_data", od2, 32'd0);
        chk("rst occupancy", 32'(occ2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst in_ready", 32'(ir2), 32'd1);

        // Stream, stall, flush, single-entry collapse.
        tbl.push_back(mk(1, A, CA, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, B, CB, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, C, CC, 1, 0, 1, A, CA, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, B, CB, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, C, CC, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, A, CA, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, B, CB, 0, 0, 0, 0, 0, 1, 1));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, A, CA, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, A, CA, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, B, CB, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, A, CA, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, B, CB, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, C, CC, 1, 1, 1, A, CA, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, A, CA, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, B, CB, 0, 0, 1, A, CA, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, A, CA, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, A, CA, 2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, B, CB, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            iv2 = tbl[i].iv; id2 = tbl[i].dat; ic2 = tbl[i].ctl;
            or2 = tbl[i].ordy; fl2 = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("t%0d out_valid", i), 32'(ov2), 32'(tbl[i].e_ov));
            chk($sformatf("t%0d out_ctrl", i), 32'(oc2), 32'(tbl[i].e_ctl));
            chk($sformatf("t%0d occupancy", i), 32'(occ2), 32'(tbl[i].e_occ));
            chk($sformatf("t%0d in_ready", i), 32'(ir2), 32'(tbl[i].e_ir));
            if (tbl[i].e_ov)
                chk($sformatf("t%0d out_data", i), od2, tbl[i].e_dat);
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-cycle with a full chain.
        iv2 = 1; id2 = A; ic2 = CA; or2 = 0; fl2 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        iv2 = 0;
        chk("midrst pre occupancy", 32'(occ2), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(ov2), 32'd0);
        chk("midrst out_ctrl", 32'(oc2), 32'd0);
        chk("midrst occupancy", 32'(occ2), 32'd0);
        chk("midrst out_data", od2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst in_ready", 32'(ir2), 32'd1);

        // Random traffic against the position model.
        q.delete();
        for (int k = 0; k < 400; k++) begin
            iv2 = ($urandom_range(0, 3) != 0);
            or2 = ($urandom_range(0, 2) != 0);
            fl2 = ($urandom_range(0, 31) == 0);
            id2 = $urandom;
            ic2 = 5'($urandom);
            model_cycle(k);
        end
        iv2 = 0; or2 = 1; fl2 = 0;
        for (int k = 0; k < 4; k++) model_cycle(400 + k);
        or2 = 0;

        // DEPTH=1: continuous input, alternating out_ready.
        sent = 0; got = 0; or_hi = 0; nxt = 32'h100;
        for (int k = 0; k < 40; k++) begin
            iv1 = 1'b1;
            id1 = nxt;
            ic1 = 5'b00001;
            or1 = k[0];
            @(negedge clk);
            e_ir1 = ~ov1 | or1;
            chk($sformatf("d1 c%0d in_ready", k), 32'(ir1), 32'(e_ir1));
            if (or1) or_hi++;
            if (ov1 && or1) begin
                got++;
                if (sb.size() == 0) begin
                    chk($sformatf("d1 c%0d spurious out", k), od1, 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("d1 c%0d out_data", k), od1, sb.pop_front());
                end
            end
            if (iv1 && e_ir1) begin
                sb.push_back(nxt);
                nxt++;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        iv1 = 0; or1 = 0;
        chk("d1 transfers per ready cycle", 32'(got), 32'(or_hi));
        chk("d1 no loss", 32'(sent), 32'(got + 1));
        @(negedge clk);
        chk("d1 resident occupancy", 32'(occ1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipe_latch_chain.md
Name: pipe_latch_chain

Overview:
- Parametrised successor to the fixed inter-stage pipeline latches: a chain of DEPTH elastic pipeline slots.
- Each slot carries a DATA_W payload, a CTRL_W control field and a valid bit.
- Uses a valid/ready handshake instead of a single global write enable, plus flush and bubble collapsing.
- Sits between any two processor stages (MEM->WB first). Also usable as a multi-cycle delay line for long-latency units.

Parameters:
- DATA_W, 32, payload width in bits (two 16-bit fields in the MEM->WB use).
- CTRL_W, 5, control width; bit 0 is REG_WRITE, bits 4:1 are dst_reg. Forced to zero in any invalid slot.
- DEPTH, 2, number of slots; legal range 1..4.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a transfer.
- in_ready  out  1  chain accepts a transfer this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- flush  in  1  squash all slots at the next edge.
- out_valid  out  1  oldest slot holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  oldest-slot payload.
- out_ctrl  out  CTRL_W  oldest-slot control field; zero when out_valid=0.
- occupancy  out  CNT_W  number of valid slots.

Behaviour:
- Reset (rst_n=0, asynchronous): every slot valid=0, ctrl=0, data=0. Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 once rst_n=1.
- Slot order: slot 0 is the input side, slot DEPTH-1 is the output side.
- Slot advance condition: adv[DEPTH-1] = ~v[DEPTH-1] | out_ready; adv[i] = ~v[i] | adv[i+1]. This is combinational and purely slot-state based, with no path from in_valid to in_ready.
- in_ready = adv[0].
- Bubble collapsing: with adv[i]=1, slot i loads slot i-1's contents at the edge (valid, ctrl, data). Slot 0 loads in_* with valid=in_valid&in_ready. When the loaded valid is 0, ctrl is loaded as 0 and data holds its old value.
- Latency: an entry accepted into an empty chain appears on out_* exactly DEPTH cycles later. Throughput is one transfer per cycle when out_ready is held high.
- Stall: out_ready=0 with a full chain gives in_ready=0. All slots hold. A held slot keeps data and ctrl bit-exact.
- Flush: at the edge, every slot valid=0 and ctrl=0. A concurrent in_valid handshake is discarded; no entry survives the flush. in_ready is still reported by the adv rule during the flush cycle. An output transfer completing in the same cycle (out_valid & out_ready) is counted as delivered downstream.
- occupancy = popcount of slot valids, registered in step with the slots. Range 0..DEPTH, never exceeds DEPTH.
- out_ctrl is gated by out_valid so downstream never sees REG_WRITE=1 from a bubble.
- Reset asserted mid-operation: all state clears immediately. Transfers in flight are lost; this is intended.
- DEPTH=1: single slot. in_ready = ~v | out_ready, giving a full-throughput registered stage.

Decomposition:
- Shared package pipe_pkg: CTRL_REG_WRITE_BIT=0, CTRL_DST_LSB=1, CTRL_DST_W=4, the MEM->WB packing of DATA_W (write_data at [15:0], read_data at [31:16]), and the legal-DEPTH check constant.
- Sub-module pipe_latch_slot: one slot holding valid, ctrl and data. Inputs are load-enable, flush, prev valid/ctrl/data. Instantiated DEPTH times in a generate loop; the chain top holds the adv logic and the occupancy counter.

Test Plan (DEPTH=2, DATA_W=32, CTRL_W=5 unless stated):
- Reset with rst_n=0 mid-cycle -> out_valid=0, out_ctrl=0, occupancy=0 immediately. in_ready=1 after release.
- Stream A=0x0000_1111, B=0x0000_2222, C=0x0000_3333 with ctrl=5'b00011 and out_ready=1 -> A seen at out on cycle 2, then B and C on consecutive cycles. in_ready stays 1.
- Fill with A, B then out_ready=0 -> occupancy=2, in_ready=0, out_data=A held 5 cycles. Raise out_ready -> A, B drain, occupancy goes 1 then 0.
- Single entry into empty chain, then out_ready=0 -> the entry collapses to slot 1 and occupancy=1. A second entry is still accepted (in_ready=1) and occupancy becomes 2.
- flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0. The flushed-cycle input never appears at the output.
- DEPTH=1 build: alternate out_ready 1/0 with continuous in_valid -> exactly one transfer per out_ready=1 cycle, no loss and no duplication, verified by a scoreboard.
